// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding, key priority indices and width helpers
// shared by the stopwatch control path.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        HALT  = 2'b11
    } sw_state_t;

    // Lower index wins when several presses land in one cycle.
    localparam int ZERO = 0;
    localparam int PAS  = 1;
    localparam int STR  = 2;
    localparam int LAP  = 3;
    localparam int NKEY = 4;

    function automatic int div_width(input int tick_div);
        return (tick_div > 2) ? $clog2(tick_div) : 1;
    endfunction

    function automatic int db_width(input int db_cycles);
        return (db_cycles > 1) ? $clog2(db_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: raw keys and counter value in, strobes, state and
// display value out.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic       str_n;
    logic       pas_n;
    logic       zero_n;
    logic       lap_n;
    logic [7:0] cnt;
    logic       cnt_en;
    logic       cnt_clr;
    logic       ovf;
    sw_state_t  state;
    logic       run;
    logic [7:0] disp;

    modport master (
        input  str_n, pas_n, zero_n, lap_n, cnt,
        output cnt_en, cnt_clr, ovf, state, run, disp
    );

    modport slave (
        output str_n, pas_n, zero_n, lap_n, cnt,
        input  cnt_en, cnt_clr, ovf, state, run, disp
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser, stability counter and a one-cycle
// pulse on an accepted press (1->0) of an active-low key.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic clr,
    input  logic key_n,
    output logic press
);
    localparam int W = db_width(DB_CYCLES);

    logic         s1;
    logic         s2;
    logic         stable;
    logic [W-1:0] ctr;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            ctr    <= '0;
            press  <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == stable) begin
                ctr <= '0;
            end else if (ctr == W'(DB_CYCLES - 1)) begin
                stable <= s2;
                ctr    <= '0;
                press  <= ~s2;
            end else begin
                ctr <= ctr + W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: key debounce, count tick and IDLE/RUN/PAUSE/HALT sequencer.
// Optional lap hold display is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000,
    parameter int MAX_COUNT = 99,
    parameter int WRAP      = 1
) (
    input logic              clk,
    input logic              clr,
    stopwatch_ctrl_if.master sw
);
    localparam int            DW       = div_width(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [7:0]    CNT_LAST = 8'(MAX_COUNT);

    sw_state_t       state;
    logic [DW-1:0]   div;
    logic [NKEY-1:0] press;
    logic [NKEY-1:0] sel;
    logic            cnt_en;
    logic            cnt_clr;
    logic            ovf;
    logic            tick;
    logic            at_max;
    logic            halting;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_zero (
        .clk(clk), .clr(clr), .key_n(sw.zero_n), .press(press[ZERO])
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_pas (
        .clk(clk), .clr(clr), .key_n(sw.pas_n), .press(press[PAS])
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_str (
        .clk(clk), .clr(clr), .key_n(sw.str_n), .press(press[STR])
    );
`ifdef STOPWATCH_LAP_HOLD_EN
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_lap (
        .clk(clk), .clr(clr), .key_n(sw.lap_n), .press(press[LAP])
    );
`else
    logic unused_lap;
    assign unused_lap = sw.lap_n;
    assign press[LAP] = 1'b0;
`endif

    // Keep only the lowest set bit: the highest-priority press.
    assign sel     = press & (~press + NKEY'(1));
    assign tick    = (state == RUN) && (div == DIV_LAST);
    assign at_max  = (sw.cnt == CNT_LAST);
    assign halting = tick && at_max && (WRAP == 0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            div     <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            ovf     <= 1'b0;
            if (state == RUN) begin
                if (tick) begin
                    div <= '0;
                    if (!at_max) begin
                        cnt_en <= 1'b1;
                    end else if (WRAP != 0) begin
                        cnt_clr <= 1'b1;
                        ovf     <= 1'b1;
                    end else begin
                        state <= HALT;
                    end
                end else begin
                    div <= div + DW'(1);
                end
            end else if (state != PAUSE) begin
                div <= '0;
            end
            // Key actions override the tick outcome where they apply.
            unique case (1'b1)
                sel[ZERO]: begin
                    state   <= IDLE;
                    div     <= '0;
                    cnt_en  <= 1'b0;
                    ovf     <= 1'b0;
                    cnt_clr <= 1'b1;
                end
                sel[PAS]: begin
                    if (state == RUN && !halting)
                        state <= PAUSE;
                end
                sel[STR]: begin
                    if (state == IDLE || state == PAUSE)
                        state <= RUN;
                end
                default: ;
            endcase
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic       hold;
    logic [7:0] held;

    always_ff @(posedge clk) begin
        if (clr) begin
            hold <= 1'b0;
            held <= '0;
        end else if (sel[ZERO]) begin
            hold <= 1'b0;
        end else if (sel[LAP] && (state == RUN || state == PAUSE)) begin
            hold <= ~hold;
            if (!hold)
                held <= sw.cnt;
        end
    end

    assign sw.disp = hold ? held : sw.cnt;
`else
    assign sw.disp = sw.cnt;
`endif

    assign sw.state   = state;
    assign sw.run     = (state == RUN);
    assign sw.cnt_en  = cnt_en;
    assign sw.cnt_clr = cnt_clr;
    assign sw.ovf     = ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table plus scripted corner sequences, with a
// behavioural counter datapath and a tick-interval monitor.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int TDIV = 10;
    localparam int DBC  = 4;
    localparam int MAXC = 99;
`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int HOLD_EN = 1;
`else
    localparam int HOLD_EN = 0;
`endif
    localparam logic [3:0] MZ = 4'(1 << ZERO);
    localparam logic [3:0] MP = 4'(1 << PAS);
    localparam logic [3:0] MS = 4'(1 << STR);
    localparam logic [3:0] ML = 4'(1 << LAP);

    typedef struct packed {
        logic [3:0] keys;
        logic [1:0] st;
        logic       clr_s;
    } vec_t;

    typedef struct packed {
        logic [1:0] st;
        logic       clr_s;
        logic       run_s;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] k1_n = '1;
    logic [3:0] k2_n = '1;
    logic [7:0] cnt_m = '0;
    logic       preload_req = 1'b0;
    logic [7:0] preload_val = '0;

    int   total = 0;
    int   passed = 0;
    int   n;
    int   m;
    int   trans;
    logic pause_seen;
    logic [1:0] prev;
    vec_t tbl [12];
    exp_t sbq [$];
    exp_t e;

    int   run_ctr = 0;
    logic armed = 1'b0;

    always #5 clk = ~clk;

    stopwatch_ctrl_if sw ();
    stopwatch_ctrl_if hw ();

    assign sw.zero_n = k1_n[ZERO];
    assign sw.pas_n  = k1_n[PAS];
    assign sw.str_n  = k1_n[STR];
    assign sw.lap_n  = k1_n[LAP];
    assign sw.cnt    = cnt_m;
    assign hw.zero_n = k2_n[ZERO];
    assign hw.pas_n  = k2_n[PAS];
    assign hw.str_n  = k2_n[STR];
    assign hw.lap_n  = k2_n[LAP];
    assign hw.cnt    = 8'(MAXC);

    stopwatch_ctrl #(
        .TICK_DIV(TDIV), .DB_CYCLES(DBC), .MAX_COUNT(MAXC), .WRAP(1)
    ) dut (
        .clk(clk), .clr(clr), .sw(sw)
    );

    stopwatch_ctrl #(
        .TICK_DIV(TDIV), .DB_CYCLES(DBC), .MAX_COUNT(MAXC), .WRAP(0)
    ) dut_halt (
        .clk(clk), .clr(clr), .sw(hw)
    );

    // Counter datapath model driven by the strobes.
    always @(posedge clk) begin
        if (clr)
            cnt_m <= '0;
        else if (preload_req)
            cnt_m <= preload_val;
        else if (sw.cnt_clr)
            cnt_m <= '0;
        else if (sw.cnt_en)
            cnt_m <= cnt_m + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total++;
        $display("FAIL %s: timeout waiting for DUT event", name);
    endtask

    // RUN cycles between consecutive ticks must be TDIV, pauses excluded.
    always @(negedge clk) begin
        if (clr) begin
            armed = 1'b0;
        end else begin
            if (sw.cnt_en || sw.cnt_clr)
                chk("strobe_excl", 32'(sw.cnt_en & sw.cnt_clr), 0);
            if (sw.cnt_en || sw.ovf) begin
                if (armed)
                    chk("tick_interval", run_ctr, TDIV);
                armed = 1'b1;
                run_ctr = (sw.state == RUN) ? 1 : 0;
            end else if (sw.cnt_clr || sw.state == IDLE || sw.state == HALT) begin
                armed = 1'b0;
            end else if (sw.state == RUN) begin
                run_ctr++;
            end
        end
    end

    task automatic tap1(input logic [3:0] msk);
        k1_n = ~msk;
        repeat (7) @(negedge clk);
        k1_n = '1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_en_at(input logic [7:0] v, input string name);
        int c = 0;
        while (!(sw.cnt_en && cnt_m == v) && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (c >= 400)
            timeout(name);
    endtask

    initial begin
        tbl[0]  = '{MS,           2'b01, 1'b0};
        tbl[1]  = '{MP,           2'b10, 1'b0};
        tbl[2]  = '{MP,           2'b10, 1'b0};
        tbl[3]  = '{MS,           2'b01, 1'b0};
        tbl[4]  = '{MZ,           2'b00, 1'b1};
        tbl[5]  = '{MP,           2'b00, 1'b0};
        tbl[6]  = '{MZ,           2'b00, 1'b1};
        tbl[7]  = '{MS | MP,      2'b00, 1'b0};
        tbl[8]  = '{MZ | MS,      2'b00, 1'b1};
        tbl[9]  = '{MS,           2'b01, 1'b0};
        tbl[10] = '{MS | MP,      2'b10, 1'b0};
        tbl[11] = '{MZ | MP | MS, 2'b00, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", sw.state, IDLE);
        chk("rst_run", sw.run, 0);
        chk("rst_strobes", {sw.cnt_en, sw.cnt_clr, sw.ovf}, 0);
        chk("rst_disp", sw.disp, 0);
        clr = 1'b0;
        @(negedge clk);

        // Start latency and tick rate
        k1_n[STR] = 1'b0;
        repeat (6) @(negedge clk);
        chk("start_lat6", sw.state, IDLE);
        @(negedge clk);
        chk("start_lat7", sw.state, RUN);
        k1_n = '1;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (sw.cnt_en) n++;
        end
        chk("en_in_50", n, 5);
        @(negedge clk);
        chk("cnt_after_50", sw.disp, 5);

        // Key decode table through the scoreboard
        for (int i = 0; i < 12; i++) begin
            k1_n = ~tbl[i].keys;
            sbq.push_back('{tbl[i].st, tbl[i].clr_s, tbl[i].st == 2'b01});
            repeat (7) @(negedge clk);
            if (sbq.size() == 0) begin
                timeout("sb_empty");
            end else begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d_state", i), sw.state, e.st);
                chk($sformatf("vec%0d_clr", i), sw.cnt_clr, e.clr_s);
                chk($sformatf("vec%0d_run", i), sw.run, e.run_s);
            end
            k1_n = '1;
            repeat (10) @(negedge clk);
        end

        // Zero and pause together in RUN
        tap1(MS);
        k1_n = ~(MZ | MP);
        n = 0;
        pause_seen = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (sw.cnt_clr) n++;
            if (sw.state == PAUSE) pause_seen = 1'b1;
        end
        k1_n = '1;
        chk("zp_clr_count", n, 1);
        chk("zp_no_pause", pause_seen, 0);
        chk("zp_state", sw.state, IDLE);
        repeat (10) @(negedge clk);

        // Pause preserves the fractional second
        tap1(MS);
        wait_en_at(8'd1, "wait_cnt1");
        repeat (7) @(negedge clk);
        k1_n[PAS] = 1'b0;
        repeat (7) @(negedge clk);
        chk("pause_state", sw.state, PAUSE);
        chk("pause_cnt", sw.disp, 3);
        k1_n = '1;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (sw.cnt_en) n++;
        end
        chk("pause_no_en", n, 0);
        k1_n[STR] = 1'b0;
        repeat (7) @(negedge clk);
        chk("resume_state", sw.state, RUN);
        k1_n = '1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!sw.cnt_en && m < 40);
        chk("resume_to_en", m, 6);

        // Wrap at terminal count
        wait_en_at(cnt_m, "wait_any_en");
        @(negedge clk);
        preload_req = 1'b1;
        preload_val = 8'(MAXC);
        @(negedge clk);
        preload_req = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!(sw.cnt_en || sw.cnt_clr || sw.ovf) && m < 40);
        chk("wrap_lat", m, 8);
        chk("wrap_clr", sw.cnt_clr, 1);
        chk("wrap_ovf", sw.ovf, 1);
        chk("wrap_no_en", sw.cnt_en, 0);
        @(negedge clk);
        chk("wrap_cnt0", sw.disp, 0);

        // Halt at terminal count without wrap
        k2_n[STR] = 1'b0;
        repeat (7) @(negedge clk);
        chk("h_run", hw.state, RUN);
        k2_n = '1;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (hw.state != HALT && m < 40);
        chk("h_lat", m, 10);
        chk("h_no_strobe", {hw.cnt_en, hw.cnt_clr, hw.ovf}, 0);
        chk("h_run_low", hw.run, 0);
        repeat (10) @(negedge clk);
        k2_n = ~MS;
        repeat (7) @(negedge clk);
        chk("h_str_ign", hw.state, HALT);
        k2_n = '1;
        repeat (10) @(negedge clk);
        k2_n = ~MP;
        repeat (7) @(negedge clk);
        chk("h_pas_ign", hw.state, HALT);
        k2_n = '1;
        repeat (10) @(negedge clk);
        k2_n = ~MZ;
        repeat (7) @(negedge clk);
        chk("h_zero_state", hw.state, IDLE);
        chk("h_zero_clr", hw.cnt_clr, 1);
        k2_n = '1;

        // Debounce glitches and long hold
        tap1(MZ);
        k1_n[STR] = 1'b0;
        repeat (2) @(negedge clk);
        k1_n = '1;
        repeat (20) @(negedge clk);
        chk("glitch2", sw.state, IDLE);
        k1_n[STR] = 1'b0;
        repeat (3) @(negedge clk);
        k1_n = '1;
        repeat (20) @(negedge clk);
        chk("glitch3", sw.state, IDLE);
        k1_n[STR] = 1'b0;
        repeat (4) @(negedge clk);
        k1_n = '1;
        repeat (3) @(negedge clk);
        chk("stable4", sw.state, RUN);
        repeat (10) @(negedge clk);
        tap1(MZ);
        k1_n[STR] = 1'b0;
        trans = 0;
        prev = sw.state;
        for (int i = 1; i <= 75; i++) begin
            @(negedge clk);
            if (i == 60) k1_n = '1;
            if (sw.state != prev) trans++;
            prev = sw.state;
        end
        chk("hold60_trans", trans, 1);
        chk("hold60_state", sw.state, RUN);

        // Lap hold display
        tap1(MZ);
        tap1(MS);
        wait_en_at(8'd11, "wait_cnt11");
        @(negedge clk);
        k1_n[LAP] = 1'b0;
        repeat (7) @(negedge clk);
        chk("lap_cap", sw.disp, 12);
        k1_n = '1;
        repeat (10) @(negedge clk);
        m = 0;
        while (cnt_m != 8'd15 && m < 100) begin
            @(negedge clk);
            m++;
        end
        if (m >= 100) timeout("wait_cnt15");
        chk("lap_hold", sw.disp, (HOLD_EN != 0) ? 12 : 15);
        k1_n[LAP] = 1'b0;
        repeat (7) @(negedge clk);
        chk("lap_free", sw.disp, 15);
        k1_n = '1;
        repeat (10) @(negedge clk);
        tap1(ML);
        k1_n[ZERO] = 1'b0;
        repeat (8) @(negedge clk);
        chk("lap_zero", sw.disp, 0);
        k1_n = '1;
        repeat (10) @(negedge clk);

        // Reset in the middle of RUN
        tap1(MS);
        clr = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", sw.state, IDLE);
        chk("mid_rst_clr", sw.cnt_clr, 0);
        chk("mid_rst_run", sw.run, 0);
        clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
